// File: rtl/qsram_access_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : qsram_access_sequencer_if
// Function : Request/response bus between a requester and the QSRAM
//            access sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface qsram_access_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, resp_valid, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/qsram_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qsram_access_sequencer
// Function : Converts valid/ready requests into row-select and Write/Read/
//            Refresh strobes for a QSRAM bank. Periodic single-row refresh is
//            built only when QSRAM_REFRESH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module qsram_access_sequencer #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int PULSE_CYCLES   = 2,
    parameter int REFRESH_PERIOD = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    qsram_access_sequencer_if.slave  req_if,
    output logic [(1<<ADDR_W)-1:0]   row_select_o,
    output logic                     write_edge_o,
    output logic                     read_edge_o,
    output logic                     refresh_edge_o,
    output logic [DATA_W-1:0]        cell_input_data_o,
    input  logic [DATA_W-1:0]        cell_output_data_i,
    output logic                     busy_o,
    output logic                     refresh_missed_o
);
    localparam int                ROWS       = 1 << ADDR_W;
    localparam int                CNT_W      = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [ROWS-1:0]   ROW_ONE    = ROWS'(1);

    if (PULSE_CYCLES < 1 || REFRESH_PERIOD < 4 + PULSE_CYCLES) begin : g_bad_params
        $error("qsram_access_sequencer: PULSE_CYCLES or REFRESH_PERIOD out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_HOLD   = 3'd3
`ifdef QSRAM_REFRESH_EN
        , ST_RSETUP = 3'd4,
        ST_RPULSE = 3'd5
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;

`ifdef QSRAM_REFRESH_EN
    localparam int                TIMER_W      = $clog2(REFRESH_PERIOD);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(REFRESH_PERIOD - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pending_q, pending_d;
    logic               missed_q, missed_d;
    logic [ADDR_W-1:0]  ref_row_q, ref_row_d;
    logic               refresh_done;
`endif

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        write_d           = write_q;
        addr_d            = addr_q;
        data_d            = data_q;
        resp_data_d       = resp_data_q;
        row_select_o      = '0;
        write_edge_o      = 1'b0;
        read_edge_o       = 1'b0;
        refresh_edge_o    = 1'b0;
        req_if.req_ready  = 1'b0;
        req_if.resp_valid = 1'b0;
`ifdef QSRAM_REFRESH_EN
        refresh_done      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef QSRAM_REFRESH_EN
                if (pending_q) begin
                    state_d = ST_RSETUP;
                end else
`endif
                begin
                    req_if.req_ready = 1'b1;
                    if (req_if.req_valid) begin
                        write_d = req_if.req_write;
                        addr_d  = req_if.req_addr;
                        data_d  = req_if.req_data;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                row_select_o = ROW_ONE << addr_q;
                cnt_d        = PULSE_LAST;
                state_d      = ST_PULSE;
            end
            ST_PULSE: begin
                row_select_o = ROW_ONE << addr_q;
                write_edge_o = write_q;
                read_edge_o  = ~write_q;
                if (cnt_q == '0) begin
                    // Cell output is sampled on the edge that closes the strobe.
                    if (!write_q) begin
                        resp_data_d = cell_output_data_i;
                    end
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                row_select_o      = ROW_ONE << addr_q;
                req_if.resp_valid = ~write_q;
                state_d           = ST_IDLE;
            end
`ifdef QSRAM_REFRESH_EN
            ST_RSETUP: begin
                row_select_o = ROW_ONE << ref_row_q;
                cnt_d        = PULSE_LAST;
                state_d      = ST_RPULSE;
            end
            ST_RPULSE: begin
                row_select_o   = ROW_ONE << ref_row_q;
                refresh_edge_o = 1'b1;
                if (cnt_q == '0) begin
                    refresh_done = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
        end
    end

`ifdef QSRAM_REFRESH_EN
    // A new expiry wins over a same-cycle clear, so pending never drops a request.
    always_comb begin
        timer_d   = timer_q - 1'b1;
        pending_d = pending_q;
        missed_d  = missed_q;
        ref_row_d = ref_row_q;
        if (refresh_done) begin
            pending_d = 1'b0;
            ref_row_d = ref_row_q + 1'b1;
        end
        if (timer_q == '0) begin
            timer_d   = TIMER_RELOAD;
            pending_d = 1'b1;
            if (pending_q) begin
                missed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q   <= TIMER_RELOAD;
            pending_q <= 1'b0;
            missed_q  <= 1'b0;
            ref_row_q <= '0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
            ref_row_q <= ref_row_d;
        end
    end

    assign refresh_missed_o = missed_q;
`else
    assign refresh_missed_o = 1'b0;
`endif

    assign cell_input_data_o = data_q;
    assign req_if.resp_data  = resp_data_q;
    assign busy_o            = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qsram_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qsram_access_sequencer
// Function : Self-checking bench for qsram_access_sequencer (timeline model
//            plus directed literal checks). Honours QSRAM_REFRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qsram_access_sequencer;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int PC     = 2;
    localparam int RP     = 6;
    localparam int ROWS   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qsram_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [ROWS-1:0]   row_select;
    logic              write_edge, read_edge, refresh_edge, busy, refresh_missed;
    logic [DATA_W-1:0] cell_in;
    logic [DATA_W-1:0] cell_out;

    qsram_access_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PULSE_CYCLES(PC), .REFRESH_PERIOD(RP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_if             (bus.slave),
        .row_select_o       (row_select),
        .write_edge_o       (write_edge),
        .read_edge_o        (read_edge),
        .refresh_edge_o     (refresh_edge),
        .cell_input_data_o  (cell_in),
        .cell_output_data_i (cell_out),
        .busy_o             (busy),
        .refresh_missed_o   (refresh_missed)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: an operation is an access (SETUP, PULSE_CYCLES strobes,
    // HOLD) or a refresh (setup + PULSE_CYCLES strobes); k counts its cycles.
    int                m_op;      // 0 idle, 1 access, 2 refresh
    int                m_k;
    bit                m_wr;
    logic [3:0]        m_addr;
    logic [7:0]        m_cid;
    logic [7:0]        m_rdata;
    bit                m_pend;
    bit                m_missed;
    logic [3:0]        m_row;
    int                m_edges;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_op = 0; m_k = 0; m_wr = 1'b0; m_addr = '0; m_cid = '0; m_rdata = '0;
            m_pend = 1'b0; m_missed = 1'b0; m_row = '0; m_edges = 0;
        end else begin
`ifdef QSRAM_REFRESH_EN
            bit pend_before;
            pend_before = m_pend;
`endif
            if (m_op == 1) begin
                if (!m_wr && m_k == PC + 1) m_rdata = cell_out;
                m_k++;
                if (m_k > PC + 2) m_op = 0;
            end else if (m_op == 2) begin
                m_k++;
                if (m_k > PC + 1) begin
                    m_op   = 0;
                    m_pend = 1'b0;
                    m_row  = m_row + 4'd1;
                end
            end else if (m_pend) begin
                m_op = 2; m_k = 1;
            end else if (bus.req_valid) begin
                m_op = 1; m_k = 1;
                m_wr   = bus.req_write;
                m_addr = bus.req_addr;
                m_cid  = bus.req_data;
            end
`ifdef QSRAM_REFRESH_EN
            m_edges++;
            if (m_edges % RP == 0) begin
                if (pend_before) m_missed = 1'b1;
                m_pend = 1'b1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        logic [15:0] e_rs;
        bit e_wr, e_rd, e_rf, e_rv, in_pulse;
        if (cmp_en && !rst) begin
            e_rs = '0; e_wr = 0; e_rd = 0; e_rf = 0; e_rv = 0;
            in_pulse = (m_k >= 2) && (m_k <= PC + 1);
            if (m_op == 1) begin
                e_rs = 16'd1 << m_addr;
                e_wr = m_wr && in_pulse;
                e_rd = !m_wr && in_pulse;
                e_rv = !m_wr && (m_k == PC + 2);
            end else if (m_op == 2) begin
                e_rs = 16'd1 << m_row;
                e_rf = (m_k >= 2);
            end
            check("row_select", 32'(row_select), 32'(e_rs));
            check("write_edge", 32'(write_edge), 32'(e_wr));
            check("read_edge", 32'(read_edge), 32'(e_rd));
            check("refresh_edge", 32'(refresh_edge), 32'(e_rf));
            check("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
            check("resp_data", 32'(bus.resp_data), 32'(m_rdata));
            check("cell_input_data", 32'(cell_in), 32'(m_cid));
            check("busy", 32'(busy), 32'(m_op != 0));
            check("req_ready", 32'(bus.req_ready), 32'(m_op == 0 && !m_pend));
            check("refresh_missed", 32'(refresh_missed), 32'(m_missed));
            check("strobe_overlap", 32'(int'(write_edge) + int'(read_edge) + int'(refresh_edge) <= 1), 32'd1);
        end
    end

    task automatic do_req(input bit w, input logic [3:0] a, input logic [7:0] d, input int gap);
        int budget;
        bit ok;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_data  = d;
        budget = 0;
        ok = 1'b0;
        while (!ok && budget < 60) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            else budget++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_accept_timeout: got no ready expected ready within 60 cycles");
        end
        @(posedge clk); #1;
        cell_out = d ^ 8'h3C;
        if (gap != 0) bus.req_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct packed {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        logic [1:0] gap;
    } req_t;

    localparam req_t REQS [12] = '{
        '{1'b1, 4'd0,  8'h11, 2'd0}, '{1'b0, 4'd0,  8'h22, 2'd0},
        '{1'b1, 4'd15, 8'hF0, 2'd1}, '{1'b0, 4'd15, 8'h0F, 2'd3},
        '{1'b0, 4'd7,  8'h81, 2'd0}, '{1'b1, 4'd8,  8'h7E, 2'd2},
        '{1'b0, 4'd1,  8'hC3, 2'd1}, '{1'b1, 4'd2,  8'h3C, 2'd0},
        '{1'b0, 4'd12, 8'h55, 2'd0}, '{1'b0, 4'd13, 8'hAA, 2'd3},
        '{1'b1, 4'd4,  8'h99, 2'd0}, '{1'b0, 4'd5,  8'h66, 2'd1}
    };

`ifndef QSRAM_REFRESH_EN
    localparam logic [15:0] WR_RS [1:5] = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0000};
    localparam logic        WR_WE [1:5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic        RD_RV [1:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic        RD_RE [1:5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic        RDY   [1:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        cell_out      = '0;

        @(negedge clk);
        check("rst_row_select", 32'(row_select), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_cell_in", 32'(cell_in), 32'd0);
        @(posedge clk); #3;
        rst    = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk); #1;

`ifndef QSRAM_REFRESH_EN
        // Write 0xA5 to row 3, accepted at edge 0.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 4'd3; bus.req_data = 8'hA5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("wr_row_select", 32'(row_select), 32'(WR_RS[c]));
            check("wr_write_edge", 32'(write_edge), 32'(WR_WE[c]));
            check("wr_resp_valid", 32'(bus.resp_valid), 32'd0);
            if (c <= 4) check("wr_cell_in", 32'(cell_in), 32'hA5);
        end
        @(posedge clk); #1;
        // Read row 3 with 0x5A presented on the cell outputs.
        cell_out = 8'h5A;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 4'd3; bus.req_data = 8'h00;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("rd_resp_valid", 32'(bus.resp_valid), 32'(RD_RV[c]));
            check("rd_read_edge", 32'(read_edge), 32'(RD_RE[c]));
            check("rd_ready", 32'(bus.req_ready), 32'(RDY[c]));
            if (c == 4) check("rd_resp_data", 32'(bus.resp_data), 32'h5A);
        end
        @(posedge clk); #1;
`endif

        foreach (REQS[i])
            do_req(REQS[i].w, REQS[i].a, REQS[i].d, int'(REQS[i].gap));
        bus.req_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end

        // Reset in the middle of a read's strobe.
        do_req(1'b0, 4'd9, 8'h42, 0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_row_select", 32'(row_select), 32'd0);
        check("arst_read_edge", 32'(read_edge), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("arst_resp_data", 32'(bus.resp_data), 32'd0);
        check("arst_cell_in", 32'(cell_in), 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 4'd9, 8'h77, 3);
        repeat (6) begin @(posedge clk); #1; end

`ifdef QSRAM_REFRESH_EN
        // Saturating traffic: refresh contends with back-to-back accesses.
        for (int i = 0; i < 40; i++)
            do_req((i % 3) == 0, 4'(i), 8'(i * 7 + 3), 0);
        bus.req_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("missed_sticky", 32'(refresh_missed), 32'd1);
        rst = 1'b1;
        #1;
        check("missed_cleared", 32'(refresh_missed), 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
`else
        // Mixed idle and traffic with the refresh logic absent.
        for (int i = 0; i < 24; i++)
            do_req((i % 2) == 0, 4'(15 - i), 8'(i * 13), i % 4);
        bus.req_valid = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/qsram_access_sequencer.md
# qsram_access_sequencer

Cycle-level controller that sits directly upstream of a bank of QSRAM cells and converts a valid/ready request stream into the row select, `WriteEdge`, `ReadEdge` and `RefreshEdge` strobes the cells consume. It drives write data onto the cell input lines and captures read data from the cell output lines. It also interleaves periodic single-row refresh cycles ahead of user traffic.

## Interface
- `ADDR_W`, 4: row address width; bank has 2^ADDR_W rows.
- `DATA_W`, 8: word width (cells per row).
- `PULSE_CYCLES`, 2: strobe width in clocks; must be ≥1.
- `REFRESH_PERIOD`, 64: clocks between refresh requests; must be ≥ 4+PULSE_CYCLES.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `Clock`  in  1  sole clock; all state on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  sequencer accepts request this cycle.
- `ReqWrite`  in  1  1 = write, 0 = read.
- `ReqAddr`  in  ADDR_W  target row.
- `ReqData`  in  DATA_W  write data.
- `RespValid`  out  1  one-cycle pulse; `RespData` is valid.
- `RespData`  out  DATA_W  captured read word; held until next read.
- `RowSelect`  out  2^ADDR_W  one-hot row enable to cells.
- `WriteEdge`, `ReadEdge`, `RefreshEdge`  out  1 each  cell strobes.
- `CellInputData`  out  DATA_W  data to cell `inputData` lines.
- `CellOutputData`  in  DATA_W  from cell `outputData` lines.
- `Busy`  out  1  state ≠ IDLE.
- `RefreshMissed`  out  1  sticky; refresh deadline hit while previous refresh still pending.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, RSETUP, RPULSE (last two only with refresh compiled in).
- IDLE: `ReqReady` = 1 iff no refresh pending. Refresh pending has priority: go to RSETUP, `ReqReady` = 0. Else on `ReqValid & ReqReady`, latch write flag, address, data, then go to SETUP.
- SETUP (1 clock): `RowSelect` = one-hot(latched addr); `CellInputData` = latched data; no strobe.
- PULSE (PULSE_CYCLES clocks): `RowSelect`/`CellInputData` held; `WriteEdge` or `ReadEdge` = 1 per latched flag.
- Read: `RespData` <= `CellOutputData` at the clock edge ending the last PULSE cycle.
- HOLD (1 clock): strobes 0, `RowSelect` held. `RespValid` = 1 only for reads. Then go to IDLE.
- RSETUP (1 clock): `RowSelect` = one-hot(`RefreshRow`).
- RPULSE (PULSE_CYCLES clocks): `RefreshEdge` = 1. On exit, clear pending, `RefreshRow` += 1 (wraps 2^ADDR_W−1 → 0), then go to IDLE.
- Refresh timer: down-counter reloaded with REFRESH_PERIOD−1. When it reaches 0, set pending and reload.
- If the timer expires while pending is already 1: pending stays 1 (no queueing) and `RefreshMissed` is set; only reset clears it.
- At most one strobe is high in any cycle. `RowSelect` is all-zero in IDLE.
- Reset (any state, mid-access included): state IDLE; all strobes 0; `RowSelect` 0; `CellInputData` 0; `RespValid` 0; `RespData` 0; `RefreshRow` 0; pending 0; `RefreshMissed` 0; timer = REFRESH_PERIOD−1. An aborted request produces no response.

## Timing
- Request accepted at edge 0: SETUP is cycle 1; PULSE is cycles 2..1+PULSE_CYCLES; HOLD is cycle 2+PULSE_CYCLES; IDLE is cycle 3+PULSE_CYCLES.
- Back-to-back throughput is one access per 3+PULSE_CYCLES clocks.
- Read latency from acceptance to `RespValid` is 2+PULSE_CYCLES clocks.
- Refresh occupies 1+PULSE_CYCLES clocks.
- `ReqReady` is registered-state-derived only; there is no combinational path from `ReqValid`.
- Request and refresh pending in the same IDLE cycle: refresh goes first. The request stays stalled (`ReqReady` = 0) and is accepted on the IDLE cycle after refresh completes.

## Configuration
- `QSRAM_REFRESH_EN` defined: refresh timer, RSETUP/RPULSE, `RefreshRow` and `RefreshMissed` are all implemented as above.
- `QSRAM_REFRESH_EN` undefined: no timer or refresh states. `RefreshEdge` is tied 0 and `RefreshMissed` is tied 0. `ReqReady` = 1 whenever in IDLE.

## Test plan
- PULSE_CYCLES=2: write 0xA5 to row 3, idle 0 cycles -> `RowSelect`=0x0008 for cycles 1–4; `WriteEdge` high cycles 2–3; `CellInputData`=0xA5; no `RespValid`.
- Read row 3 with `CellOutputData`=0x5A during PULSE -> `RespValid` pulses at cycle 4 with `RespData`=0x5A; `ReqReady` returns high at cycle 5.
- REFRESH_PERIOD=8 with continuous `ReqValid`: refresh wins in IDLE, `RefreshEdge` high 2 cycles; `RefreshRow` steps 0,1,…,15,0 across 17 refreshes; no strobe overlap.
- REFRESH_PERIOD=6, PULSE_CYCLES=2, with refresh blocked by back-to-back accesses -> `RefreshMissed` goes 1 and stays 1 until `Reset`.
- Assert `Reset` during PULSE of a read -> all outputs are zero asynchronously, no `RespValid`, next request completes normally.
- With `QSRAM_REFRESH_EN` undefined: 200 cycles of idle and traffic -> `RefreshEdge` is never 1; `ReqReady` is 1 in every IDLE cycle.
